// File: rtl/pp_buf_bank.sv
// Ping-pong double buffer: two banks of COLS x DEPTH x DATA_W, one filled by a loader while the other is read.
// Optional macro PP_BUF_BANK_OVF_ERR_EN adds the sticky ld_err overflow flag.
module pp_buf_bank #(
    parameter int COLS   = 4,
    parameter int DATA_W = 72,
    parameter int DEPTH  = 256,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ld_ready,
    input  logic [COLS-1:0]        ld_wr_en,
    input  logic [COLS*AW-1:0]     ld_wr_addr,
    input  logic [COLS*DATA_W-1:0] ld_din,
    input  logic                   ld_done,
    output logic                   cp_ready,
    input  logic                   cp_rd_en,
    input  logic [COLS*AW-1:0]     cp_rd_addr,
    output logic [COLS*DATA_W-1:0] cp_dout,
    output logic                   cp_dout_valid,
    input  logic                   cp_done,
    output logic [1:0]             bank_full
`ifdef PP_BUF_BANK_OVF_ERR_EN
    ,
    output logic                   ld_err
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;

    bank_state_t state [2];
    bank_state_t state_n [2];
    logic        ld_sel, ld_sel_n;
    logic        cp_sel, cp_sel_n;
    logic        ld_fire, cp_fire, rd_fire;

    logic [DATA_W-1:0] mem [2][COLS][DEPTH];

    // Non-power-of-two depths leave a hole at the top of the address space.
    localparam bit AW_EXACT = (DEPTH == (1 << AW));

    function automatic logic in_range(input logic [AW-1:0] a);
        return AW_EXACT || (int'(a) < DEPTH);
    endfunction

    assign ld_ready  = (state[ld_sel] == EMPTY);
    assign cp_ready  = (state[cp_sel] == FULL);
    assign bank_full = {state[1] == FULL, state[0] == FULL};
    assign ld_fire   = ld_done && ld_ready;
    assign cp_fire   = cp_done && cp_ready;
    assign rd_fire   = cp_rd_en && cp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state[0] <= EMPTY;
            state[1] <= EMPTY;
            ld_sel   <= 1'b0;
            cp_sel   <= 1'b0;
        end else begin
            state  <= state_n;
            ld_sel <= ld_sel_n;
            cp_sel <= cp_sel_n;
        end
    end

    always_comb begin
        state_n  = state;
        ld_sel_n = ld_sel;
        cp_sel_n = cp_sel;
        if (ld_fire) begin
            state_n[ld_sel] = FULL;
            ld_sel_n        = ~ld_sel;
        end
        // ld_sel==cp_sel forbids both firing, so the two updates never collide.
        if (cp_fire) begin
            state_n[cp_sel] = EMPTY;
            cp_sel_n        = ~cp_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ld_ready) begin
            for (int unsigned j = 0; j < COLS; j++) begin
                if (ld_wr_en[j] && in_range(ld_wr_addr[j*AW +: AW]))
                    mem[ld_sel][j][ld_wr_addr[j*AW +: AW]] <= ld_din[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cp_dout       <= '0;
            cp_dout_valid <= 1'b0;
        end else begin
            cp_dout_valid <= rd_fire;
            if (rd_fire) begin
                for (int unsigned j = 0; j < COLS; j++) begin
                    cp_dout[j*DATA_W +: DATA_W] <= in_range(cp_rd_addr[j*AW +: AW])
                        ? mem[cp_sel][j][cp_rd_addr[j*AW +: AW]] : '0;
                end
            end
        end
    end

`ifdef PP_BUF_BANK_OVF_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ld_err <= 1'b0;
        else if (!ld_ready && ((|ld_wr_en) || ld_done))
            ld_err <= 1'b1;
    end
`endif

endmodule
